seg7_scan_driver: RTL and testbench

Multiplexed 4-digit common-anode 7-segment display driver. It consumes the four BCD digits produced by the stopwatch counter (s0 least significant to s3 most significant) and time-multiplexes them onto one shared segment bus with per-digit anode enables. It sits between the counter and the board's display pins. It snapshots the digits once per scan frame, inserts an anti-ghosting blank interval in each digit slot, decodes BCD to active-low segments, and drives the decimal point.

---
 rtl/seg7_scan_driver.sv | 126 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment scan driver with per-frame digit snapshot and blank interval.
// Optional leading-zero blanking is compiled in when SEG_LZ_BLANK_EN is defined.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int DP_DIGIT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] s3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [1:0]       DP_IDX    = 2'(DP_DIGIT);

  typedef enum logic {BLANK, DRIVE} phase_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       snap_q [4];
  logic [3:0]       snap_d [4];
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  phase_t           phase;
  logic [3:0]       cur_digit;
  logic             lz_blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = 7'h3F;
    endcase
  endfunction

  assign phase     = (cnt_q < CNT_BLANK) ? BLANK : DRIVE;
  assign cur_digit = snap_q[idx_q];

`ifdef SEG_LZ_BLANK_EN
  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lz_blank = 1'b0;
    case (idx_q)
      2'd3:    lz_blank = (snap_q[3] == 4'd0);
      2'd2:    lz_blank = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0);
      2'd1:    lz_blank = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0) && (snap_q[1] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Disabling parks the scan at cnt=0, idx=0, so the first enabled cycle is always a frame start.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (!en) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else begin
      if (cnt_q == '0 && idx_q == 2'd0) begin
        snap_d[0] = s0;
        snap_d[1] = s1;
        snap_d[2] = s2;
        snap_d[3] = s3;
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (phase == DRIVE) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = lz_blank ? 7'h7F : bcd_to_seg(cur_digit);
        dp_d  = (idx_q != DP_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      snap_q <= '{4'd0, 4'd0, 4'd0, 4'd0};
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: time-based display model plus directed literal checkpoints.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int DPD   = 2;

  logic       clk = 1'b0;
  logic       reset, en;
  logic [3:0] s0, s1, s2, s3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks_total  = 0;
  int checks_passed = 0;

  seg7_scan_driver #(
    .REFRESH_DIV(DIV),
    .BLANK_CYCLES(BLANK),
    .DP_DIGIT(DPD)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_table [16];
  initial seg_table = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] ZERO_LEAD = 7'h7F;
`else
  localparam logic [6:0] ZERO_LEAD = 7'h40;
`endif

  // Model: t counts enabled cycles since reset or enable; slot/position follow from plain division.
  int         t = 0;
  logic [3:0] m_snap [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  bit         model_valid = 0;

  function automatic logic [6:0] model_seg(input int slot);
    bit all_zero = 1;
    for (int k = slot; k < 4; k++) if (m_snap[k] != 4'd0) all_zero = 0;
`ifdef SEG_LZ_BLANK_EN
    if (slot > 0 && all_zero) return 7'h7F;
`endif
    return seg_table[m_snap[slot]];
  endfunction

  always @(posedge clk) begin
    int pos, slot;
    model_valid = 1;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    if (reset) begin
      t = 0;
      for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
    end else if (!en) begin
      t = 0;
    end else begin
      if (t % (4 * DIV) == 0) begin
        m_snap[0] = s0; m_snap[1] = s1; m_snap[2] = s2; m_snap[3] = s3;
      end
      pos  = t % DIV;
      slot = (t / DIV) % 4;
      if (pos >= BLANK) begin
        exp_an  = 4'(15 - (1 << slot));
        exp_seg = model_seg(slot);
        exp_dp  = (slot == DPD) ? 1'b0 : 1'b1;
      end
      t++;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
    checks_total++;
    if (an === e_an && seg === e_seg && dp === e_dp)
      checks_passed++;
    else
      $display("[TB] FAIL %s @%0t: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, $time, an, seg, dp, e_an, e_seg, e_dp);
  endtask

  always @(negedge clk) begin
    if (model_valid) checkOutput("model", exp_an, exp_seg, exp_dp);
  end

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] d3,
                               input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    reset = r; en = e; s3 = d3; s2 = d2; s1 = d1; s0 = d0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    applyStimulus(1, 1, 4'd1, 4'd2, 4'd3, 4'd4);
    waitCycles(3);
    checkOutput("reset_hold", 4'hF, 7'h7F, 1'b1);
    applyStimulus(0, 1, 4'd1, 4'd2, 4'd3, 4'd4);
    waitCycles(1);  checkOutput("post_reset_dark", 4'hF, 7'h7F, 1'b1);
    waitCycles(2);  checkOutput("first_drive_d0", 4'hE, 7'h19, 1'b1);
    waitCycles(6);  checkOutput("slot1_blank", 4'hF, 7'h7F, 1'b1);
    waitCycles(2);  checkOutput("drive_d1", 4'hD, 7'h30, 1'b1);
    waitCycles(8);  checkOutput("drive_d2_dp", 4'hB, 7'h24, 1'b0);
    waitCycles(8);  checkOutput("drive_d3", 4'h7, 7'h79, 1'b1);
    waitCycles(8);  checkOutput("frame2_d0", 4'hE, 7'h19, 1'b1);
    waitCycles(8);  checkOutput("frame2_d1", 4'hD, 7'h30, 1'b1);
    applyStimulus(0, 1, 4'd1, 4'd2, 4'd3, 4'd9);
    waitCycles(16); checkOutput("snap_hold_d3", 4'h7, 7'h79, 1'b1);
    waitCycles(8);  checkOutput("snap_new_d0", 4'hE, 7'h10, 1'b1);
    applyStimulus(0, 1, 4'd1, 4'd2, 4'hC, 4'd9);
    waitCycles(40); checkOutput("invalid_bcd_d1", 4'hD, 7'h3F, 1'b1);
    waitCycles(8);  checkOutput("invalid_other_d2", 4'hB, 7'h24, 1'b0);
    applyStimulus(0, 1, 4'd0, 4'd0, 4'd0, 4'd7);
    waitCycles(16); checkOutput("lz_d0", 4'hE, 7'h78, 1'b1);
    waitCycles(8);  checkOutput("lz_d1", 4'hD, ZERO_LEAD, 1'b1);
    waitCycles(8);  checkOutput("lz_d2_dp", 4'hB, ZERO_LEAD, 1'b0);
    applyStimulus(0, 0, 4'd0, 4'd0, 4'd0, 4'd5);
    waitCycles(1);  checkOutput("en_drop_dark", 4'hF, 7'h7F, 1'b1);
    waitCycles(3);
    applyStimulus(0, 1, 4'd0, 4'd0, 4'd0, 4'd5);
    waitCycles(1);  checkOutput("en_restart_dark", 4'hF, 7'h7F, 1'b1);
    waitCycles(2);  checkOutput("en_restart_d0", 4'hE, 7'h12, 1'b1);
    waitCycles(8);  checkOutput("en_restart_d1", 4'hD, ZERO_LEAD, 1'b1);
    waitCycles(3);
    applyStimulus(1, 1, 4'd0, 4'd0, 4'd0, 4'd5);
    waitCycles(1);  checkOutput("mid_frame_reset", 4'hF, 7'h7F, 1'b1);
    applyStimulus(0, 1, 4'd0, 4'd0, 4'd0, 4'd5);
    waitCycles(3);  checkOutput("after_reset_d0", 4'hE, 7'h12, 1'b1);
    waitCycles(40);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
